// File: rtl/cactus_scroller_if.sv
// Signal bundle between the VGA timing/game control side and the cactus scroller.
// The master drives counters and controls; the slave returns the cactus state.
interface cactus_scroller_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        run;
    logic        restart;
    logic [9:0]  cactus_x;
    logic        cactus_active;
    logic [3:0]  speed;
    logic [15:0] passed_count;
    logic        frame_tick;

    modport master (
        output hcount, vcount, run, restart,
        input  cactus_x, cactus_active, speed, passed_count, frame_tick
    );

    modport slave (
        input  hcount, vcount, run, restart,
        output cactus_x, cactus_active, speed, passed_count, frame_tick
    );
endinterface

// File: rtl/cactus_scroller.sv
// Cactus obstacle position generator: scrolls, despawns, waits a random gap,
// respawns, and speeds up as cacti are passed. Updates once per frame tick.
module cactus_scroller #(
    parameter int SCALED_WIDTH = 96,
    parameter int SPAWN_X      = 640,
    parameter int TICK_LINE    = 480,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 12,
    parameter int SPEED_STEP   = 4,
    parameter int MIN_GAP      = 30,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic pix_clk,
    input  logic rst_n,
    cactus_scroller_if.slave bus
);

    localparam logic [9:0] SPAWN = 10'(SPAWN_X);
    localparam logic [9:0] TLINE = 10'(TICK_LINE);
    localparam logic [3:0] SPD0  = 4'(INIT_SPEED);
    localparam logic [3:0] SPDMX = 4'(MAX_SPEED);
    localparam logic [6:0] GAP0  = 7'(MIN_GAP);
    localparam logic [15:0] STEP = 16'(SPEED_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        GAP    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic        active_q, active_d;
    logic [3:0]  speed_q, speed_d;
    logic [15:0] passed_q, passed_d;
    logic        tick_q, tick_d;
    logic [6:0]  gap_q, gap_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] passed_inc;
    logic [9:0]  speed_ext;

    always_comb begin
        tick_d     = (bus.hcount == 10'd0) && (bus.vcount == TLINE);
        lfsr_d     = lfsr_q;
        state_d    = state_q;
        x_d        = x_q;
        active_d   = active_q;
        speed_d    = speed_q;
        passed_d   = passed_q;
        gap_d      = gap_q;
        passed_inc = passed_q + 16'd1;
        speed_ext  = {6'd0, speed_q};

        // The LFSR free-runs on every frame, even when paused or restarting.
        if (tick_q)
            lfsr_d = {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (bus.restart) begin
            state_d  = IDLE;
            x_d      = SPAWN;
            active_d = 1'b0;
            speed_d  = SPD0;
            passed_d = 16'd0;
            gap_d    = 7'd0;
        end else if (tick_q && bus.run) begin
            unique case (state_q)
                IDLE: begin
                    state_d  = SCROLL;
                    x_d      = SPAWN;
                    active_d = 1'b1;
                end
                SCROLL: begin
                    if (x_q > speed_ext) begin
                        x_d = x_q - speed_ext;
                    end else begin
                        state_d  = GAP;
                        active_d = 1'b0;
                        passed_d = passed_inc;
                        gap_d    = GAP0 + {1'b0, lfsr_q[5:0]};
                        if ((passed_inc % STEP) == 16'd0)
                            speed_d = (speed_q >= SPDMX) ? SPDMX
                                                         : speed_q + 4'd1;
                    end
                end
                GAP: begin
                    if (gap_q == 7'd0) begin
                        state_d  = SCROLL;
                        x_d      = SPAWN;
                        active_d = 1'b1;
                    end else begin
                        gap_d = gap_q - 7'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    x_d      = SPAWN;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= SPAWN;
            active_q <= 1'b0;
            speed_q  <= SPD0;
            passed_q <= 16'd0;
            tick_q   <= 1'b0;
            gap_q    <= 7'd0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            active_q <= active_d;
            speed_q  <= speed_d;
            passed_q <= passed_d;
            tick_q   <= tick_d;
            gap_q    <= gap_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign bus.cactus_x      = x_q;
    assign bus.cactus_active = active_q;
    assign bus.speed         = speed_q;
    assign bus.passed_count  = passed_q;
    assign bus.frame_tick    = tick_q;

endmodule

// File: tb/tb_cactus_scroller.sv
// Bench for cactus_scroller: vector table, corner sequences and a
// randomized run compared every cycle against a behavioural model.
module tb_cactus_scroller;

    localparam int SPAWN   = 640;
    localparam int TLINE   = 480;
    localparam int SPD0    = 2;
    localparam int SPDMAX  = 12;
    localparam int STEP    = 4;
    localparam int MINGAP  = 30;
    localparam int M_IDLE  = 0;
    localparam int M_SCRL  = 1;
    localparam int M_GAP   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cactus_scroller_if bus ();

    cactus_scroller dut (
        .pix_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit cur_run = 1'b0;

    int m_x, m_speed, m_passed, m_mode, m_gap_left;
    bit m_ft;
    logic [7:0] m_lfsr;

    typedef struct {
        bit run;
        bit rs;
        int x;
        bit act;
        int spd;
        int pas;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = SPAWN;
        m_speed = SPD0;
        m_passed = 0;
        m_mode = M_IDLE;
        m_gap_left = 0;
        m_ft = 1'b0;
        m_lfsr = 8'hA5;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(bit tickpat, bit rs, bit rn);
        bit ft;
        logic [7:0] l;
        ft = m_ft;
        l = m_lfsr;
        if (rs) begin
            m_mode = M_IDLE;
            m_x = SPAWN;
            m_speed = SPD0;
            m_passed = 0;
            m_gap_left = 0;
        end else if (ft && rn) begin
            if (m_mode == M_IDLE) begin
                m_mode = M_SCRL;
            end else if (m_mode == M_SCRL) begin
                if (m_x > m_speed) begin
                    m_x = m_x - m_speed;
                end else begin
                    m_mode = M_GAP;
                    m_passed = (m_passed + 1) % 65536;
                    m_gap_left = MINGAP + (int'(l) % 64) + 1;
                    if (m_passed % STEP == 0 && m_speed < SPDMAX)
                        m_speed = m_speed + 1;
                end
            end else begin
                m_gap_left = m_gap_left - 1;
                if (m_gap_left == 0) begin
                    m_x = SPAWN;
                    m_mode = M_SCRL;
                end
            end
        end
        if (ft)
            m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        m_ft = tickpat;
    endtask

    task automatic cmp_model();
        chk("x", 32'(bus.cactus_x), 32'(m_x));
        chk("active", 32'(bus.cactus_active), 32'(m_mode == M_SCRL));
        chk("speed", 32'(bus.speed), 32'(m_speed));
        chk("passed", 32'(bus.passed_count), 32'(m_passed));
        chk("frame_tick", 32'(bus.frame_tick), 32'(m_ft));
    endtask

    task automatic step(bit tickpat, bit rs);
        @(posedge clk);
        model_edge(tickpat, rs, cur_run);
        #1;
        cmp_model();
    endtask

    // Three-cycle frame: tick pattern, tick-visible cycle, filler cycle.
    task automatic frame(bit rn, bit rs_tick, bit rs_fill);
        cur_run = rn;
        bus.run = rn;
        bus.hcount = 10'd0;
        bus.vcount = 10'(TLINE);
        bus.restart = 1'b0;
        step(1'b1, 1'b0);
        bus.hcount = 10'd1;
        bus.restart = rs_tick;
        step(1'b0, rs_tick);
        bus.hcount = 10'(1 + $urandom_range(0, 798));
        bus.vcount = 10'($urandom_range(0, 524));
        bus.restart = rs_fill;
        step(1'b0, rs_fill);
        bus.restart = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames;
        bit first_seen;
        vecs[0] = '{1, 0, 640, 1, 2, 0};
        vecs[1] = '{1, 0, 638, 1, 2, 0};
        vecs[2] = '{1, 0, 636, 1, 2, 0};
        vecs[3] = '{1, 0, 634, 1, 2, 0};
        vecs[4] = '{0, 0, 634, 1, 2, 0};
        vecs[5] = '{0, 0, 634, 1, 2, 0};
        vecs[6] = '{1, 0, 632, 1, 2, 0};
        vecs[7] = '{1, 1, 640, 0, 2, 0};
        vecs[8] = '{1, 0, 640, 1, 2, 0};
        vecs[9] = '{1, 0, 638, 1, 2, 0};

        bus.hcount = 10'd5;
        bus.vcount = 10'd5;
        bus.run = 1'b0;
        bus.restart = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 32'(bus.cactus_x), 32'd640);
        chk("rst_speed", 32'(bus.speed), 32'd2);
        chk("rst_passed", 32'(bus.passed_count), 32'd0);
        chk("rst_active", 32'(bus.cactus_active), 32'd0);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            frame(vecs[i].run, vecs[i].rs, 1'b0);
            chk($sformatf("vec%0d_x", i), 32'(bus.cactus_x), 32'(vecs[i].x));
            chk($sformatf("vec%0d_act", i),
                32'(bus.cactus_active), 32'(vecs[i].act));
            chk($sformatf("vec%0d_spd", i), 32'(bus.speed), 32'(vecs[i].spd));
            chk($sformatf("vec%0d_pas", i),
                32'(bus.passed_count), 32'(vecs[i].pas));
        end

        // Asynchronous reset mid-frame while scrolling.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(bus.cactus_x), 32'd640);
        chk("arst_speed", 32'(bus.speed), 32'd2);
        chk("arst_passed", 32'(bus.passed_count), 32'd0);
        chk("arst_active", 32'(bus.cactus_active), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Long run to the speed ceiling, with sporadic pauses.
        frames = 0;
        first_seen = 1'b0;
        while (m_passed < 44 && frames < 20000) begin
            frame(($urandom % 8) != 0, 1'b0, 1'b0);
            frames++;
            if (!first_seen && m_passed == 1) begin
                first_seen = 1'b1;
                chk("despawn_x", 32'(bus.cactus_x), 32'd2);
                chk("despawn_act", 32'(bus.cactus_active), 32'd0);
                chk("despawn_pas", 32'(bus.passed_count), 32'd1);
            end
        end
        chk("long_run_done", 32'(m_passed >= 44), 32'd1);
        chk("speed_sat", 32'(bus.speed), 32'd12);

        // Pause: outputs frozen while frame_tick keeps pulsing.
        for (int i = 0; i < 10; i++)
            frame(1'b0, 1'b0, 1'b0);

        frames = 0;
        while (m_mode != M_GAP && frames < 2000) begin
            frame(1'b1, 1'b0, 1'b0);
            frames++;
        end
        chk("reach_gap", 32'(m_mode), 32'(M_GAP));
        frame(1'b1, 1'b1, 1'b0);
        chk("rs_gap_x", 32'(bus.cactus_x), 32'd640);
        chk("rs_gap_speed", 32'(bus.speed), 32'd2);
        chk("rs_gap_passed", 32'(bus.passed_count), 32'd0);
        chk("rs_gap_active", 32'(bus.cactus_active), 32'd0);

        for (int i = 0; i < 1500; i++)
            frame(($urandom % 6) != 0, ($urandom % 200) == 0,
                  ($urandom % 300) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
